// File: rtl/sa_deskew.sv
// Systolic-array output deskew: lane k is delayed by LANES-1-k stages so that a
// diagonally skewed wavefront leaves as one aligned, framed output beat.
module sa_deskew #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int ROWS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       i_vld,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   o_vld,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   o_last,
  output logic                   o_err
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROWS - 1);

  logic [LANES-1:0]       aln_vld;
  logic [LANES*WIDTH-1:0] aln_data;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   all_vld;
  logic                   part_vld;

  // Per-lane delay lines; the last lane passes straight to the output register.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int D = LANES - 1 - k;
    if (D == 0) begin : g_pass
      assign aln_vld[k]                  = i_vld[k];
      assign aln_data[k*WIDTH +: WIDTH]  = in_data[k*WIDTH +: WIDTH];
    end else begin : g_dly
      logic [D-1:0]     vld_sr;
      logic [WIDTH-1:0] dat_sr [D];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr <= '0;
          for (int i = 0; i < D; i++) dat_sr[i] <= '0;
        end else begin
          vld_sr[0] <= i_vld[k];
          dat_sr[0] <= in_data[k*WIDTH +: WIDTH];
          for (int i = 1; i < D; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            dat_sr[i] <= dat_sr[i-1];
          end
        end
      end

      assign aln_vld[k]                 = vld_sr[D-1];
      assign aln_data[k*WIDTH +: WIDTH] = dat_sr[D-1];
    end
  end

  assign all_vld  = &aln_vld;
  assign part_vld = (|aln_vld) && !all_vld;

  // Aligned stage -> output register, frame counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld    <= 1'b0;
      o_last   <= 1'b0;
      o_err    <= 1'b0;
      out_data <= '0;
      beat_cnt <= '0;
    end else begin
      o_vld  <= all_vld;
      o_last <= all_vld && (beat_cnt == CNT_MAX);
      if (all_vld) begin
        out_data <= aln_data;
        beat_cnt <= (beat_cnt == CNT_MAX) ? '0 : beat_cnt + 1'b1;
      end
      if (part_vld) o_err <= 1'b1;
    end
  end

endmodule

// File: doc/sa_deskew.md
SA_DESKEW -- requirements
Module: sa_deskew

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of one lane element.
REQ-002 SHALL have parameter LANES, default 4: number of skewed lanes (systolic array columns), LANES >= 1.
REQ-003 SHALL have parameter ROWS, default 4: output beats per frame, ROWS >= 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_vld, input, LANES bits: bit k is the valid for lane k.
REQ-007 SHALL have port in_data, input, LANES*WIDTH bits: lane k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port o_vld, output, 1 bit: aligned output beat valid.
REQ-009 SHALL have port out_data, output, LANES*WIDTH bits: aligned beat, same lane packing as in_data.
REQ-010 SHALL have port o_last, output, 1 bit: marks the last beat of a frame.
REQ-011 SHALL have port o_err, output, 1 bit: sticky misalignment flag.

Function
REQ-012 SHALL delay lane k (data and valid together) by LANES-1-k register stages; lane LANES-1 has zero delay stages.
REQ-013 SHALL register the aligned stage into out_data/o_vld, so lane k sampled at edge t+k appears at the outputs after edge t+LANES.
REQ-014 SHALL assert o_vld for exactly one cycle per aligned set in which all LANES delayed valids are 1.
REQ-015 SHALL update out_data only on beats where o_vld is asserted; otherwise out_data holds its last value.
REQ-016 SHALL treat an aligned set with some, but not all, valids set as misaligned: set o_err, keep o_vld low, leave out_data unchanged, and leave the beat counter unchanged.
REQ-017 SHALL hold o_err at 1 once it is set, until reset.
REQ-018 SHALL keep a beat counter, 0..ROWS-1, that increments on each asserted o_vld beat and wraps from ROWS-1 to 0.
REQ-019 SHALL assert o_last together with o_vld on the beat where the counter equals ROWS-1; when ROWS=1, every valid beat is also last.
REQ-020 SHALL accept a new aligned set every cycle, with no bubbles required between frames.
REQ-021 SHALL implement LANES=1 as a single output register with latency 1.
REQ-022 SHALL not generate backpressure: every aligned valid set is always accepted.

Reset
REQ-023 SHALL, while rst_n=0, immediately clear all delay-stage valids and data, out_data, o_vld, o_last, o_err and the beat counter to 0.
REQ-024 SHALL discard any data in flight when reset is asserted mid-operation; no stale beat may emerge after reset is released.
REQ-025 SHALL resume after reset release with the first complete aligned set treated as beat 0 of a new frame.

Verification
Scenarios use WIDTH=16, LANES=4, ROWS=2.
REQ-026 Aligned beat: lane k valid at edge t+k with data 16'h1000+k -> after edge t+4, o_vld=1, out_data={16'h1003,16'h1002,16'h1001,16'h1000}, o_last=0.
REQ-027 Back-to-back frame: two skewed sets on consecutive cycles, with values A then B -> o_vld high for 2 consecutive cycles; o_last=0 on beat A and o_last=1 on beat B; the next beat has o_last=0 (counter has wrapped).
REQ-028 Misalignment: lane 2 valid one cycle late -> o_err=1 from then on, no o_vld for the broken set, out_data unchanged; a later correct set still gives o_vld=1.
REQ-029 Idle: i_vld=0 for 20 cycles -> o_vld=0 and out_data constant throughout.
REQ-030 Reset mid-stream: rst_n=0 while 3 skewed lanes are in flight, then rst_n=1 -> all outputs 0 immediately; no o_vld until a fresh full set arrives, and that set is beat 0.
REQ-031 LANES=1 build: i_vld=1 with in_data=16'hABCD at edge t -> after edge t+1, o_vld=1 and out_data=16'hABCD; with ROWS=1, o_last=1.
